// File: rtl/goldschmidt_pkg.sv
// Shared types and constants for the sequential Goldschmidt divider.
// Values are unsigned fixed point with FRAC fractional bits.
package goldschmidt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned W_DEF    = 8;
   localparam int unsigned FRAC_DEF = 6;
   localparam logic [7:0]  F0_DEF   = 8'h30;

   function automatic int unsigned calcOne(input int unsigned frac);
      return 32'd1 << frac;
   endfunction

   function automatic int unsigned calcTwo(input int unsigned frac);
      return 32'd2 << frac;
   endfunction

endpackage

// File: rtl/goldschmidt_step.sv
// One combinational Goldschmidt refinement: scales N and D by F and
// derives the next correction factor F' = 2 - D'.
module goldschmidt_step
   import goldschmidt_pkg::*;
#(
   parameter int unsigned W    = W_DEF,
   parameter int unsigned FRAC = FRAC_DEF
) (
   input  logic [W-1:0] n_i,
   input  logic [W-1:0] d_i,
   input  logic [W-1:0] f_i,
   output logic [W-1:0] n_o,
   output logic [W-1:0] d_o,
   output logic [W-1:0] f_o,
   output logic         satN_o,
   output logic         satD_o
);

   localparam logic [W-1:0] TWO = W'(calcTwo(FRAC));

   logic [2*W-1:0] prodN;
   logic [2*W-1:0] prodD;
   logic [2*W-1:0] shiftN;
   logic [2*W-1:0] shiftD;

   // Any bit left above the datapath width after renormalising means the
   // value no longer fits and is clamped to full scale.
   always_comb begin
      prodN  = {{W{1'b0}}, n_i} * {{W{1'b0}}, f_i};
      prodD  = {{W{1'b0}}, d_i} * {{W{1'b0}}, f_i};
      shiftN = prodN >> FRAC;
      shiftD = prodD >> FRAC;
      satN_o = |shiftN[2*W-1:W];
      satD_o = |shiftD[2*W-1:W];
      n_o    = satN_o ? {W{1'b1}} : shiftN[W-1:0];
      d_o    = satD_o ? {W{1'b1}} : shiftD[W-1:0];
      f_o    = TWO - d_o;
   end

endmodule

// File: rtl/goldschmidt_seq_ctrl.sv
// Sequential Goldschmidt divider controller: runs one shared step per cycle
// until D converges to 1.0 or the iteration budget is used up.
module goldschmidt_seq_ctrl
   import goldschmidt_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned FRAC  = FRAC_DEF,
   parameter int unsigned ITERS = 4,
   parameter logic [W-1:0] F0   = W'(F0_DEF)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] q,
   output logic         dz,
   output logic         sat,
   output logic [3:0]   iters_used
);

   localparam logic [W-1:0] ONE     = W'(calcOne(FRAC));
   localparam logic [3:0]   ITERS_C = 4'(ITERS);

   state_e       state_q, state_d;
   logic [W-1:0] num_q, num_d;
   logic [W-1:0] den_q, den_d;
   logic [W-1:0] fac_q, fac_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         satAcc_q, satAcc_d;
   logic [W-1:0] quo_q, quo_d;
   logic         dz_q, dz_d;
   logic         satOut_q, satOut_d;
   logic [3:0]   itersUsed_q, itersUsed_d;
   logic         done_q, done_d;

   logic [W-1:0] stepN, stepD, stepF;
   logic         stepSatN, stepSatD;
   logic [3:0]   cntNext;
   logic         satNext;

   goldschmidt_step #(
      .W    (W),
      .FRAC (FRAC)
   ) u_step (
      .n_i    (num_q),
      .d_i    (den_q),
      .f_i    (fac_q),
      .n_o    (stepN),
      .d_o    (stepD),
      .f_o    (stepF),
      .satN_o (stepSatN),
      .satD_o (stepSatD)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         num_q       <= '0;
         den_q       <= '0;
         fac_q       <= '0;
         cnt_q       <= '0;
         satAcc_q    <= 1'b0;
         quo_q       <= '0;
         dz_q        <= 1'b0;
         satOut_q    <= 1'b0;
         itersUsed_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         den_q       <= den_d;
         fac_q       <= fac_d;
         cnt_q       <= cnt_d;
         satAcc_q    <= satAcc_d;
         quo_q       <= quo_d;
         dz_q        <= dz_d;
         satOut_q    <= satOut_d;
         itersUsed_q <= itersUsed_d;
         done_q      <= done_d;
      end
   end

   // Result registers are only written on the way into DONE so the previous
   // answer stays visible while the next division is in flight.
   always_comb begin
      state_d     = state_q;
      num_d       = num_q;
      den_d       = den_q;
      fac_d       = fac_q;
      cnt_d       = cnt_q;
      satAcc_d    = satAcc_q;
      quo_d       = quo_q;
      dz_d        = dz_q;
      satOut_d    = satOut_q;
      itersUsed_d = itersUsed_q;
      done_d      = 1'b0;
      cntNext     = cnt_q + 4'd1;
      satNext     = satAcc_q | stepSatN | stepSatD;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (b != '0) begin
                  num_d    = a;
                  den_d    = b;
                  fac_d    = F0;
                  cnt_d    = '0;
                  satAcc_d = 1'b0;
                  state_d  = ITER;
               end else begin
                  quo_d       = {W{1'b1}};
                  dz_d        = 1'b1;
                  satOut_d    = 1'b0;
                  itersUsed_d = '0;
                  done_d      = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         ITER: begin
            num_d    = stepN;
            den_d    = stepD;
            fac_d    = stepF;
            cnt_d    = cntNext;
            satAcc_d = satNext;
            if ((stepD == ONE) || (cntNext == ITERS_C)) begin
               quo_d       = stepN;
               dz_d        = 1'b0;
               satOut_d    = satNext;
               itersUsed_d = cntNext;
               done_d      = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy       = (state_q == ITER);
   assign done       = done_q;
   assign q          = quo_q;
   assign dz         = dz_q;
   assign sat        = satOut_q;
   assign iters_used = itersUsed_q;

endmodule

// File: tb/tb_goldschmidt_seq_ctrl.sv
// Directed bench for goldschmidt_seq_ctrl with hand-computed Q2.6 results.
module tb_goldschmidt_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] q;
   logic       dz;
   logic       sat;
   logic [3:0] itersUsed;

   int assertCount = 0;
   int failCount   = 0;
   int lat;
   int busySeen;
   int doneSeen;

   goldschmidt_seq_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .q          (q),
      .dz         (dz),
      .sat        (sat),
      .iters_used (itersUsed)
   );

   always #5 clk = ~clk;

   // Outputs are observed 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("[TB] %s differs", tag);
      end
   endtask

   // Presents one start pulse and counts cycles until done (bounded).
   task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn,
                                output int latOut, output int busyOut);
      a       = aIn;
      b       = bIn;
      start   = 1'b1;
      latOut  = 0;
      busyOut = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         start = 1'b0;
         latOut++;
         if (busy) busyOut = 1;
         if (done) break;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      tick();
      tick();
      checkOutput("rst_q", q, 8'h00);
      checkOutput("rst_busy", 8'(busy), 8'd0);
      checkOutput("rst_done", 8'(done), 8'd0);
      checkOutput("rst_dz", 8'(dz), 8'd0);
      checkOutput("rst_sat", 8'(sat), 8'd0);
      checkOutput("rst_iters", 8'(itersUsed), 8'd0);
      rst = 1'b0;
      tick();

      $display("[TB] case 1: 1.0 / 1.0, full iteration budget");
      applyStimulus(8'h40, 8'h40, lat, busySeen);
      checkOutput("c1_lat", 8'(lat), 8'd5);
      checkOutput("c1_q", q, 8'h3F);
      checkOutput("c1_iters", 8'(itersUsed), 8'd4);
      checkOutput("c1_sat", 8'(sat), 8'd0);
      checkOutput("c1_dz", 8'(dz), 8'd0);
      checkOutput("c1_busy", 8'(busySeen), 8'd1);
      tick();
      checkOutput("c1_done_pulse", 8'(done), 8'd0);
      checkOutput("c1_q_held", q, 8'h3F);

      $display("[TB] case 2: early convergence after one step");
      applyStimulus(8'h40, 8'h56, lat, busySeen);
      checkOutput("c2_lat", 8'(lat), 8'd2);
      checkOutput("c2_q", q, 8'h30);
      checkOutput("c2_iters", 8'(itersUsed), 8'd1);
      tick();

      $display("[TB] case 3: numerator saturates");
      applyStimulus(8'hFF, 8'h08, lat, busySeen);
      checkOutput("c3_lat", 8'(lat), 8'd5);
      checkOutput("c3_q", q, 8'hFF);
      checkOutput("c3_sat", 8'(sat), 8'd1);
      checkOutput("c3_iters", 8'(itersUsed), 8'd4);
      checkOutput("c3_dz", 8'(dz), 8'd0);
      tick();

      $display("[TB] case 4: divide by zero");
      applyStimulus(8'h55, 8'h00, lat, busySeen);
      checkOutput("c4_lat", 8'(lat), 8'd1);
      checkOutput("c4_q", q, 8'hFF);
      checkOutput("c4_dz", 8'(dz), 8'd1);
      checkOutput("c4_sat", 8'(sat), 8'd0);
      checkOutput("c4_iters", 8'(itersUsed), 8'd0);
      checkOutput("c4_busy", 8'(busySeen), 8'd0);
      tick();

      $display("[TB] case 5: start repeated during ITER is ignored");
      a     = 8'h40;
      b     = 8'h40;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      a     = 8'hFF;
      b     = 8'h08;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat   = 3;
      for (int i = 0; i < 40; i++) begin
         if (done) break;
         tick();
         lat++;
      end
      checkOutput("c5_lat", 8'(lat), 8'd5);
      checkOutput("c5_q", q, 8'h3F);
      checkOutput("c5_iters", 8'(itersUsed), 8'd4);
      checkOutput("c5_sat", 8'(sat), 8'd0);
      checkOutput("c5_dz", 8'(dz), 8'd0);
      tick();

      $display("[TB] case 6: reset in third ITER cycle aborts");
      a     = 8'hFF;
      b     = 8'h08;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      checkOutput("c6_busy_pre", 8'(busy), 8'd1);
      rst = 1'b1;
      #1;
      checkOutput("c6_q", q, 8'h00);
      checkOutput("c6_busy", 8'(busy), 8'd0);
      checkOutput("c6_iters", 8'(itersUsed), 8'd0);
      checkOutput("c6_done", 8'(done), 8'd0);
      tick();
      rst      = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done || busy) doneSeen = 1;
      end
      checkOutput("c6_no_done", 8'(doneSeen), 8'd0);

      $display("[TB] case 7: normal division after reset");
      applyStimulus(8'h40, 8'h56, lat, busySeen);
      checkOutput("c7_lat", 8'(lat), 8'd2);
      checkOutput("c7_q", q, 8'h30);
      checkOutput("c7_iters", 8'(itersUsed), 8'd1);

      $display("[TB] case 8: start in DONE ignored, accepted in following IDLE");
      a     = 8'h40;
      b     = 8'h40;
      start = 1'b1;
      tick();
      checkOutput("c8_idle_busy", 8'(busy), 8'd0);
      checkOutput("c8_idle_done", 8'(done), 8'd0);
      tick();
      start = 1'b0;
      checkOutput("c8_accept_busy", 8'(busy), 8'd1);
      checkOutput("c8_q_stable", q, 8'h30);
      checkOutput("c8_iters_stable", 8'(itersUsed), 8'd1);
      lat = 1;
      for (int i = 0; i < 40; i++) begin
         if (done) break;
         tick();
         lat++;
      end
      checkOutput("c8_lat", 8'(lat), 8'd5);
      checkOutput("c8_q", q, 8'h3F);
      checkOutput("c8_iters", 8'(itersUsed), 8'd4);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
